// File: rtl/md_pad_responder.sv
// md_pad_responder: device-side Mega Drive gamepad emulator for the DB9 port.
// Watches the SELECT line from a console/reader and answers on the six
// active-low DB9 data lines with 3-button or 6-button multiplexed frames.
// Optional feature macro: SIX_BUTTON_EN (defined = 6-button protocol with
// edge counting and idle timeout; undefined = plain 3-button pad).
module md_pad_responder #(
  parameter int TIMEOUT_CYCLES = 75000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdsel,
  input  logic [11:0] buttons,
  output logic [5:0]  pad_out,
  output logic [2:0]  phase
);

  // buttons: 11 M, 10 S, 9 Z, 8 Y, 7 X, 6 C, 5 B, 4 A, 3 U, 2 D, 1 L, 0 R
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic [5:0]             w_frame;

  // SELECT synchronizer; resets to the idle-high level so no edge follows reset
  always_ff @(posedge clk) begin
    if (reset) r_sync <= '1;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], mdsel};
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef SIX_BUTTON_EN
  localparam logic [19:0] TO = 20'(TIMEOUT_CYCLES);

  logic        w_s_next;
  logic        w_fall;
  logic        w_edge;
  logic [19:0] r_idle;
  logic [19:0] w_idle_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;

  // Edge detect on the last two stages: the edge lands in the same cycle
  // that the new level reaches w_s, so cnt and s update together.
  assign w_s_next = r_sync[SYNC_STAGES-2];
  assign w_fall   = w_s & ~w_s_next;
  assign w_edge   = w_s ^ w_s_next;

  // Next idle-timer and falling-edge count; an edge beats a same-cycle timeout
  always_comb begin
    w_idle_nxt = r_idle;
    w_cnt_nxt  = r_cnt;
    if (w_edge)           w_idle_nxt = 20'd0;
    else if (r_idle != TO) w_idle_nxt = r_idle + 20'd1;
    if (w_fall) begin
      if (r_cnt != 3'd4) w_cnt_nxt = r_cnt + 3'd1;
    end else if (!w_edge && (w_idle_nxt == TO)) begin
      w_cnt_nxt = 3'd0;
    end
  end

  // Idle timer and edge count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle <= 20'd0;
      r_cnt  <= 3'd0;
    end else begin
      r_idle <= w_idle_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign phase = r_cnt;

  // Frame select from the registered select level and count
  always_comb begin
    w_frame = 6'h3F;
    if (w_s) begin
      if (r_cnt == 3'd3)
        w_frame = ~{buttons[6], buttons[5], buttons[9], buttons[8], buttons[7], buttons[11]};
      else
        w_frame = ~{buttons[6], buttons[5], buttons[3], buttons[2], buttons[1], buttons[0]};
    end else begin
      case (r_cnt)
        3'd3:    w_frame = {~buttons[10], ~buttons[4], 4'b0000};
        3'd4:    w_frame = {~buttons[10], ~buttons[4], 4'b1111};
        default: w_frame = {~buttons[10], ~buttons[4], ~buttons[3], ~buttons[2], 2'b00};
      endcase
    end
  end
`else
  // M, X, Y, Z have no meaning on a 3-button pad
  logic w_unused;
  assign w_unused = ^{buttons[11], buttons[9:7]};

  assign phase = 3'd0;

  // Plain 3-button frame select
  always_comb begin
    w_frame = 6'h3F;
    if (w_s) w_frame = ~{buttons[6], buttons[5], buttons[3], buttons[2], buttons[1], buttons[0]};
    else     w_frame = {~buttons[10], ~buttons[4], ~buttons[3], ~buttons[2], 2'b00};
  end
`endif

  // Registered DB9 data lines
  always_ff @(posedge clk) begin
    if (reset) pad_out <= 6'h3F;
    else       pad_out <= w_frame;
  end

endmodule
